chacha_stream_ctrl: RTL and testbench
=====================================

// Module: chacha_stream_ctrl
// PURPOSE
//  Sequencer that drives the chacha register-bus wrapper (cs/we/addr/write_data/read_data).
//  - Programs key, IV, keylen and rounds, and zeroes data_in, so data_out is pure keystream.
//  - Issues init, then next, for a requested number of 512-bit blocks.
//  - Streams each block out as 16 x 32-bit words on a valid/ready interface.
//  - Sits between the stream-cipher DMA/XOR datapath and the chacha instance; it is that instance's only bus master.
// PARAMETERS
//  POLL_GAP   2   idle cycles after a CTRL write before the first STATUS poll (min 1)
//  BLK_W      16  width of the block-count input/counter
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  start       in   1      1-cycle request; inputs below sampled on this cycle
//  num_blocks  in   BLK_W  blocks to generate; 0 = no-op
//  key         in   256    key, word 0 = key[255:224] -> addr 0x10
//  keylen      in   1      1 = 256-bit key, 0 = 128-bit key
//  iv          in   64     iv[63:32] -> 0x20, iv[31:0] -> 0x21
//  rounds      in   5      round count written to 0x0b (8/12/20)
//  busy        out  1      high from the cycle after accepted start until done
//  done        out  1      1-cycle pulse after the last word is accepted
//  ks_data     out  32     keystream word (registered)
//  ks_valid    out  1      ks_data valid; held until ks_ready
//  ks_ready    in   1      consumer accepts word when ks_valid & ks_ready
//  cc_cs       out  1      chacha bus chip select
//  cc_we       out  1      chacha bus write enable
//  cc_addr     out  8      chacha bus address
//  cc_wdata    out  32     chacha bus write data
//  cc_rdata    in   32     chacha bus read data (combinational, same cycle as cs & !we)
// BEHAVIOUR
//  Reset (async): state IDLE; every output 0; all counters 0. The chacha wrapper resets
//   itself from the same net.
//  IDLE: start & num_blocks!=0 -> latch inputs; blk_cnt = num_blocks; go to CFG.
//   start & num_blocks==0 -> done pulses next cycle, no bus traffic, busy stays 0.
//   start while busy is ignored.
//  CFG: one write per cycle, cs=we=1, fixed order:
//   0x0a keylen, 0x0b rounds, 0x10..0x17 key, 0x20..0x21 iv, 0x40..0x4f = 0.
//   28 cycles total, then CTRL.
//  CTRL: one write to 0x08; wdata = 32'h1 (init) for the first block, 32'h2 (next) after that.
//  GAP: POLL_GAP cycles with cs=0.
//  POLL: read 0x09 every cycle; leave when cc_rdata[1:0]==2'b11 (valid & ready).
//  FETCH: read 0x80+w; register cc_rdata into ks_data; assert ks_valid next cycle.
//  EMIT: hold ks_data/ks_valid stable until ks_ready.
//   - On accept: w wraps 15->0 at end of block.
//   - w<15: back to FETCH.
//   - w==15 and blk_cnt>1: decrement blk_cnt, go to CTRL (next).
//   - w==15 and blk_cnt==1: DONE.
//   Min 2 cycles/word; no FETCH while ks_valid & !ks_ready.
//  DONE: done=1 for one cycle, busy=0, return to IDLE.
//  Bus rules:
//   - cc_cs is high only in CFG/CTRL/POLL/FETCH; cc_we only in CFG/CTRL.
//   - cc_addr/cc_wdata are 0 when cc_cs=0.
//   - Exactly one write per CFG/CTRL cycle, never two per cycle.
//  Core block counter starts at 0 on init and advances internally on next; the controller never
//   rewrites key/iv between blocks.
//  Reset mid-operation: immediate abort to IDLE; the partial block is discarded, no done pulse.
// TESTING
//  1. key=0, iv=0, keylen=1, rounds=20, num_blocks=1, ks_ready=1
//     -> 28 CFG writes in the order above, one CTRL write of 0x1, then 16 words.
//     -> Word 0 carries keystream bytes 76 b8 e0 ad, packed per the core's data_out word order.
//     -> Every word matches the chacha_core model; done pulses once.
//  2. num_blocks=3 -> CTRL writes 0x1, 0x2, 0x2; 48 words; block 2 matches model counter=1;
//     blk_cnt reaches 0 exactly at done.
//  3. ks_ready low for 10 cycles at word 5 -> ks_data/ks_valid stable; no bus read issued;
//     no word lost or duplicated.
//  4. start with num_blocks=0 -> done next cycle; cc_cs never asserted; busy=0.
//  5. Second start while busy -> ignored; latched key unchanged; the first job completes normally.
//  6. reset_n low during POLL of block 2
//     -> all outputs 0 asynchronously; after release, a fresh start reproduces test 1 output exactly.

Source files
------------

// File: rtl/chacha_stream_ctrl_if.sv
// chacha_stream_ctrl_if: chacha register bus plus keystream valid/ready channel.
interface chacha_stream_ctrl_if;
  logic        cc_cs;
  logic        cc_we;
  logic [7:0]  cc_addr;
  logic [31:0] cc_wdata;
  logic [31:0] cc_rdata;
  logic [31:0] ks_data;
  logic        ks_valid;
  logic        ks_ready;
  modport master (
    output cc_cs, cc_we, cc_addr, cc_wdata, ks_data, ks_valid,
    input  cc_rdata, ks_ready
  );
  modport slave (
    input  cc_cs, cc_we, cc_addr, cc_wdata, ks_data, ks_valid,
    output cc_rdata, ks_ready
  );
endinterface

// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: programs chacha, issues init/next, streams 16 keystream words per block.
module chacha_stream_ctrl #(
  parameter int POLL_GAP = 2,
  parameter int BLK_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BLK_W-1:0]     num_blocks,
  input  logic [255:0]         key,
  input  logic                 keylen,
  input  logic [63:0]          iv,
  input  logic [4:0]           rounds,
  output logic                 busy,
  output logic                 done,
  chacha_stream_ctrl_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, CFG = 3'd1, CTRL = 3'd2, GAP = 3'd3,
                         POLL = 3'd4, FETCH = 3'd5, EMIT = 3'd6, DONE = 3'd7;
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  logic [2:0]       state;
  logic [4:0]       cfg_idx;
  logic [GW-1:0]    gap_cnt;
  logic [3:0]       w;
  logic [BLK_W-1:0] blk_cnt;
  logic             first;
  logic [255:0]     key_r;
  logic [63:0]      iv_r;
  logic             keylen_r;
  logic [4:0]       rounds_r;
  logic [2:0]       k;
  logic [4:0]       z;
  logic [7:0]       cfg_addr;
  logic [31:0]      cfg_data;
  // cfg_idx 0-1 keylen/rounds, 2-9 key words, 10-11 iv, 12-27 zeroed data_in
  always_comb begin
    k = cfg_idx[2:0] - 3'd2;
    z = cfg_idx - 5'd12;
    cfg_addr = cfg_idx < 5'd2  ? {7'h05, cfg_idx[0]} :
               cfg_idx < 5'd10 ? {5'h02, k} :
               cfg_idx < 5'd12 ? {7'h10, cfg_idx[0]} : {4'h4, z[3:0]};
    cfg_data = cfg_idx == 5'd0 ? {31'b0, keylen_r} :
               cfg_idx == 5'd1 ? {27'b0, rounds_r} :
               cfg_idx < 5'd10 ? key_r[{3'd7 - k, 5'd0} +: 32] :
               cfg_idx == 5'd10 ? iv_r[63:32] :
               cfg_idx == 5'd11 ? iv_r[31:0] : 32'h0;
  end
  assign bus.cc_cs    = state == CFG || state == CTRL || state == POLL || state == FETCH;
  assign bus.cc_we    = state == CFG || state == CTRL;
  assign bus.cc_addr  = state == CFG   ? cfg_addr :
                        state == CTRL  ? 8'h08 :
                        state == POLL  ? 8'h09 :
                        state == FETCH ? {4'h8, w} : 8'h00;
  assign bus.cc_wdata = state == CFG  ? cfg_data :
                        state == CTRL ? (first ? 32'h1 : 32'h2) : 32'h0;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      cfg_idx      <= '0;
      gap_cnt      <= '0;
      w            <= '0;
      blk_cnt      <= '0;
      first        <= 1'b0;
      key_r        <= '0;
      iv_r         <= '0;
      keylen_r     <= 1'b0;
      rounds_r     <= '0;
      bus.ks_data  <= '0;
      bus.ks_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state    <= num_blocks == '0 ? DONE : CFG;
          blk_cnt  <= num_blocks;
          key_r    <= key;
          iv_r     <= iv;
          keylen_r <= keylen;
          rounds_r <= rounds;
          first    <= 1'b1;
          cfg_idx  <= '0;
          w        <= '0;
        end
        CFG: begin
          cfg_idx <= cfg_idx + 5'd1;
          if (cfg_idx == 5'd27) state <= CTRL;
        end
        CTRL: begin
          first   <= 1'b0;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(POLL_GAP - 1)) state <= POLL;
        end
        POLL: if (bus.cc_rdata[1:0] == 2'b11) state <= FETCH;
        FETCH: begin
          bus.ks_data  <= bus.cc_rdata;
          bus.ks_valid <= 1'b1;
          state        <= EMIT;
        end
        EMIT: if (bus.ks_ready) begin
          bus.ks_valid <= 1'b0;
          w            <= w + 4'd1;
          state        <= w != 4'd15 ? FETCH : blk_cnt > 1 ? CTRL : DONE;
          if (w == 4'd15) blk_cnt <= blk_cnt - 1'b1;
        end
        DONE: state <= IDLE;
      endcase
endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// tb_chacha_stream_ctrl: directed checks of the chacha sequencer against a behavioural bus slave.
module tb_chacha_stream_ctrl;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [15:0]  num_blocks;
  logic [255:0] key;
  logic         keylen;
  logic [63:0]  iv;
  logic [4:0]   rounds;
  logic         busy, done;
  int total = 0, bad = 0;
  int done_total = 0, cs_total = 0, idle_bad = 0, we_bad = 0;
  logic [39:0] wlog[$];
  logic [31:0] wq[$];
  logic [31:0] t1_words[16];
  logic [3:0]  lat;
  logic [15:0] blk;

  chacha_stream_ctrl_if bus();
  chacha_stream_ctrl #(.POLL_GAP(2), .BLK_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks), .key(key),
    .keylen(keylen), .iv(iv), .rounds(rounds), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] kw(input int b, input int w);
    return (b == 0 && w == 0) ? 32'h76b8e0ad : 32'hc0de0000 | 32'(b << 8) | 32'(w);
  endfunction

  function automatic logic [39:0] exp_cfg(input int i, input logic [255:0] k, input logic [63:0] v,
                                          input logic kl, input logic [4:0] r);
    if (i == 0) return {8'h0a, 31'b0, kl};
    if (i == 1) return {8'h0b, 27'b0, r};
    if (i < 10) return {8'(8'h10 + i - 2), k[255 - 32 * (i - 2) -: 32]};
    if (i == 10) return {8'h20, v[63:32]};
    if (i == 11) return {8'h21, v[31:0]};
    return {8'(8'h40 + i - 12), 32'h0};
  endfunction

  function automatic int cfg_errs(input int base, input logic [255:0] k, input logic [63:0] v,
                                  input logic kl, input logic [4:0] r);
    int e = 0;
    if (wlog.size() < base + 28) return 99;
    for (int i = 0; i < 28; i++) if (wlog[base + i] !== exp_cfg(i, k, v, kl, r)) e++;
    return e;
  endfunction

  function automatic int ctrl_count(input int base);
    int c = 0;
    for (int i = base; i < wlog.size(); i++) if (wlog[i][39:32] == 8'h08) c++;
    return c;
  endfunction

  // chacha core stand-in: logs writes, tracks block counter, ready 4 cycles after init/next
  assign bus.cc_rdata = !(bus.cc_cs && !bus.cc_we) ? 32'h0 :
                        bus.cc_addr == 8'h09 ? {30'b0, {2{lat == 4'd0}}} :
                        bus.cc_addr[7:4] == 4'h8 ? kw(int'(blk), int'(bus.cc_addr[3:0])) : 32'h0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lat <= 4'd0;
      blk <= 16'd0;
    end else if (bus.cc_cs && bus.cc_we) begin
      wlog.push_back({bus.cc_addr, bus.cc_wdata});
      if (bus.cc_addr == 8'h08) begin
        lat <= 4'd4;
        blk <= bus.cc_wdata == 32'h1 ? 16'd0 : blk + 16'd1;
      end
    end else if (lat != 4'd0) lat <= lat - 4'd1;

  always begin
    @(negedge clk);
    #4;
    if (reset_n) begin
      if (bus.ks_valid && bus.ks_ready) wq.push_back(bus.ks_data);
      if (done) done_total++;
      if (bus.cc_cs) cs_total++;
      if (!bus.cc_cs && (bus.cc_addr != 8'h0 || bus.cc_wdata != 32'h0)) idle_bad++;
      if (bus.cc_we && !bus.cc_cs) we_bad++;
    end
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [15:0] nb, input logic [255:0] k, input logic [63:0] v,
                      input logic kl, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; num_blocks = nb; key = k; iv = v; keylen = kl; rounds = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_total == base && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 80'(done_total != base), 80'd1);
  endtask

  localparam logic [255:0] KA = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
  localparam logic [255:0] KB = 256'hffffffff_eeeeeeee_dddddddd_cccccccc_bbbbbbbb_aaaaaaaa_99999999_88888888;
  localparam logic [63:0]  IVA = 64'hdeadbeef_cafef00d;

  initial begin
    int bl, bw, bd, bc, e, n, hold_bad;
    logic [31:0] hd;
    logic [5:0] cseq;
    reset_n = 1'b0; start = 1'b0; num_blocks = '0; key = '0; iv = '0; keylen = 1'b0; rounds = '0;
    bus.ks_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {bus.cc_cs, bus.cc_we, bus.cc_addr, bus.cc_wdata, bus.ks_valid, busy, done}, 80'd0);
    chk("rst_ks_data", bus.ks_data, 80'd0);
    reset_n = 1'b1;

    // 1: single block, zero key
    bl = wlog.size(); bw = wq.size(); bd = done_total;
    kick(16'd1, '0, '0, 1'b1, 5'd20);
    chk("t1_busy", busy, 1);
    wait_done(bd);
    chk("t1_nwrites", wlog.size() - bl, 29);
    chk("t1_cfg", cfg_errs(bl, '0, '0, 1'b1, 5'd20), 0);
    chk("t1_ctrl", wlog[bl + 28], {8'h08, 32'h1});
    chk("t1_nwords", wq.size() - bw, 16);
    chk("t1_word0", wq[bw], 32'h76b8e0ad);
    e = 0;
    for (int i = 0; i < 16; i++) begin
      t1_words[i] = wq[bw + i];
      if (wq[bw + i] !== kw(0, i)) e++;
    end
    chk("t1_words", e, 0);
    chk("t1_done", done_total - bd, 1);
    chk("t1_idle_busy", busy, 0);

    // 2: three blocks, distinctive key, 128-bit, 12 rounds
    bl = wlog.size(); bw = wq.size(); bd = done_total;
    kick(16'd3, KA, IVA, 1'b0, 5'd12);
    wait_done(bd);
    chk("t2_cfg", cfg_errs(bl, KA, IVA, 1'b0, 5'd12), 0);
    bc = 0; cseq = '0;
    for (int i = bl; i < wlog.size(); i++)
      if (wlog[i][39:32] == 8'h08) begin
        cseq = {cseq[3:0], wlog[i][1:0]};
        bc++;
      end
    chk("t2_nctrl", bc, 3);
    chk("t2_ctrlseq", cseq, 6'b01_10_10);
    chk("t2_nwords", wq.size() - bw, 48);
    chk("t2_blk1_w0", wq[bw + 16], kw(1, 0));
    e = 0;
    for (int i = 0; i < 48; i++) if (wq[bw + i] !== kw(i / 16, i % 16)) e++;
    chk("t2_words", e, 0);
    chk("t2_done", done_total - bd, 1);

    // 3: backpressure on word 5
    bw = wq.size(); bd = done_total;
    kick(16'd1, '0, '0, 1'b1, 5'd20);
    n = 0;
    while (wq.size() - bw < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bus.ks_ready = 1'b0;
    n = 0;
    while (!bus.ks_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_valid", bus.ks_valid, 1);
    hd = bus.ks_data; hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.ks_valid || bus.ks_data !== hd || bus.cc_cs) hold_bad++;
    end
    chk("t3_hold", hold_bad, 0);
    chk("t3_held_word", hd, kw(0, 5));
    chk("t3_cnt5", wq.size() - bw, 5);
    bus.ks_ready = 1'b1;
    wait_done(bd);
    chk("t3_nwords", wq.size() - bw, 16);
    e = 0;
    for (int i = 0; i < 16; i++) if (wq[bw + i] !== kw(0, i)) e++;
    chk("t3_words", e, 0);

    // 4: zero blocks
    bc = cs_total; bl = wlog.size(); bd = done_total;
    kick(16'd0, KA, IVA, 1'b1, 5'd8);
    chk("t4_done", {done, busy}, 2'b10);
    @(negedge clk);
    chk("t4_done_clr", {done, busy}, 2'b00);
    repeat (3) @(negedge clk);
    chk("t4_no_cs", cs_total - bc, 0);
    chk("t4_no_wr", wlog.size() - bl, 0);
    chk("t4_done_cnt", done_total - bd, 1);

    // 5: second start while busy is ignored
    bl = wlog.size(); bw = wq.size(); bd = done_total;
    kick(16'd2, KA, IVA, 1'b1, 5'd20);
    repeat (5) @(negedge clk);
    chk("t5_busy", busy, 1);
    kick(16'd1, KB, 64'h1, 1'b0, 5'd8);
    wait_done(bd);
    chk("t5_cfg", cfg_errs(bl, KA, IVA, 1'b1, 5'd20), 0);
    chk("t5_nctrl", ctrl_count(bl), 2);
    chk("t5_nwords", wq.size() - bw, 32);
    bl = wlog.size(); bd = done_total;
    repeat (60) @(negedge clk);
    chk("t5_quiet", {wlog.size() - bl, done_total - bd}, 0);

    // 6: reset during POLL of block 2
    bl = wlog.size(); bd = done_total;
    kick(16'd2, KA, IVA, 1'b1, 5'd20);
    n = 0;
    while (!(ctrl_count(bl) == 2 && bus.cc_cs && !bus.cc_we && bus.cc_addr == 8'h09) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_poll", {bus.cc_cs, bus.cc_addr}, {1'b1, 8'h09});
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {bus.cc_cs, bus.cc_we, bus.cc_addr, bus.cc_wdata, bus.ks_valid, busy, done}, 80'd0);
    chk("t6_rst_ks", bus.ks_data, 80'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("t6_no_done", done_total - bd, 0);
    bw = wq.size(); bd = done_total;
    kick(16'd1, '0, '0, 1'b1, 5'd20);
    wait_done(bd);
    chk("t6_nwords", wq.size() - bw, 16);
    e = 0;
    for (int i = 0; i < 16; i++) if (wq[bw + i] !== t1_words[i]) e++;
    chk("t6_repro", e, 0);

    chk("bus_idle_zero", idle_bad, 0);
    chk("bus_we_no_cs", we_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
